// File: rtl/pwm_dac_gen.sv
// rtl/pwm_dac_gen.sv - dithered PWM DAC generator with per-frame config latch
//
// Purpose: Generates a PWM stream whose duty is a base value V plus a one-bit
// dither B[k] that varies across the 16 cycles of a frame. The average duty
// over a frame therefore has 4 bits more resolution than the PWM period
// alone provides.
//
// Ports:
//   clk_i      clock, all logic on the rising edge
//   rst_i      asynchronous active-high reset
//   cfg_i      [23:16] base duty V, [15:0] dither pattern B (bit k -> cycle k)
//   pwm_o      registered PWM output
//   frame_o    high on the first clock of each 16-cycle frame
//   cfg_ack_o  high in the clock where cfg_i is sampled (last clock of a frame)

module pwm_dac_gen #(
    parameter int PERIOD = 156,
    parameter int CNT_W  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] cfg_i,
    output logic        pwm_o,
    output logic        frame_o,
    output logic        cfg_ack_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    // Compare width wide enough for both the cycle counter and the 9-bit threshold.
    localparam int CMP_W = (CNT_W > 9) ? CNT_W : 9;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [7:0]       v_q, v_d;
    logic [15:0]      b_q, b_d;
    logic [8:0]       thr_q, thr_d;
    logic             pwm_q, pwm_d;

    logic             cyc_end;
    logic             frame_end;
    logic [CMP_W-1:0] cnt_ext;
    logic [CMP_W-1:0] thr_ext;

    always_comb begin
        cyc_end   = (cnt_q == CNT_MAX);
        frame_end = cyc_end && (bcnt_q == 4'hF);

        cnt_d  = cyc_end ? '0 : cnt_q + 1'b1;
        bcnt_d = cyc_end ? bcnt_q + 4'd1 : bcnt_q;

        // Config is only sampled on the last clock of a frame so a frame
        // always uses one consistent V/B pair.
        v_d = v_q;
        b_d = b_q;
        if (frame_end) begin
            v_d = cfg_i[23:16];
            b_d = cfg_i[15:0];
        end

        // Threshold for the upcoming cycle uses the upcoming cycle index and
        // the V/B that will be in force then (fresh values at a frame edge).
        // Kept at 9 bits so 255 + 1 does not wrap.
        thr_d = thr_q;
        if (cyc_end) begin
            thr_d = {1'b0, v_d} + {8'b0, b_d[bcnt_d]};
        end

        // A threshold >= PERIOD keeps the output high through the wrap since
        // even cnt == PERIOD-1 compares below it.
        cnt_ext = CMP_W'(cnt_q);
        thr_ext = CMP_W'(thr_q);
        pwm_d   = (cnt_ext < thr_ext);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            bcnt_q <= '0;
            v_q    <= '0;
            b_q    <= '0;
            thr_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bcnt_q <= bcnt_d;
            v_q    <= v_d;
            b_q    <= b_d;
            thr_q  <= thr_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign frame_o   = (cnt_q == '0) && (bcnt_q == 4'd0);
    assign cfg_ack_o = frame_end;

endmodule

// File: tb/tb_pwm_dac_gen.sv
// tb/tb_pwm_dac_gen.sv - directed self-checking bench for pwm_dac_gen

module tb_pwm_dac_gen;

    localparam int P     = 156;
    localparam int FRAME = 16 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cfg = 24'h0;
    logic        pwm;
    logic        frame;
    logic        ack;

    int total = 0;
    int bad   = 0;

    pwm_dac_gen #(.PERIOD(P), .CNT_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cfg_i     (cfg),
        .pwm_o     (pwm),
        .frame_o   (frame),
        .cfg_ack_o (ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Samples one frame's worth of clocks. Cycle c's high clocks appear at
    // samples c*P+1 .. c*P+P (one clock of output latency), so sample FRAME
    // is the first clock of the next frame. v/b are the values the frame is
    // expected to use; cfg is changed to chg_val at sample chg_at.
    task automatic run_frame(input string tag, input int v, input int b,
                             input int chg_at, input logic [23:0] chg_val,
                             input int exp_sum);
        int hc[16];
        int ferr, aerr, sum, nbad, e;
        ferr = 0; aerr = 0; sum = 0; nbad = 0;
        for (int c = 0; c < 16; c++) hc[c] = 0;
        for (int s = 1; s <= FRAME; s++) begin
            @(negedge clk);
            hc[(s - 1) / P] += int'(pwm);
            if (frame !== (s == FRAME)) ferr++;
            if (ack !== (s == FRAME - 1)) aerr++;
            if (s == chg_at) cfg = chg_val;
        end
        for (int c = 0; c < 16; c++) begin
            e = v + ((b >> c) & 1);
            if (e > P) e = P;
            if (hc[c] != e) nbad++;
            sum += hc[c];
        end
        check_val({tag, "_cycles"}, nbad, 0);
        check_val({tag, "_sum"}, sum, exp_sum);
        check_val({tag, "_frame"}, ferr, 0);
        check_val({tag, "_ack"}, aerr, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("frame_at_release", int'(frame), 1);
    endtask

    initial begin
        cfg = 24'h000000;
        repeat (3) @(negedge clk);
        check_val("rst_pwm", int'(pwm), 0);
        check_val("rst_frame", int'(frame), 1);
        check_val("rst_ack", int'(ack), 0);

        release_reset();
        run_frame("zero_f1", 0, 0, 0, 24'h000000, 0);
        run_frame("zero_f2", 0, 0, 0, 24'h000000, 0);
        // Mid-frame change must not affect the current frame.
        run_frame("zero_f3", 0, 0, 1000, 24'h4E0000, 0);
        run_frame("half", 8'h4E, 0, 1000, 24'h9C0000, 1248);
        run_frame("full", 8'h9C, 0, 5, 24'h0F0001, 2496);
        run_frame("v15_b1", 8'h0F, 16'h0001, 5, 24'h9B0001, 241);
        run_frame("v155_b1", 8'h9B, 16'h0001, 5, 24'hFF0000, 2481);
        run_frame("sat_ff", 8'hFF, 0, 5, 24'hFFFFFF, 2496);
        run_frame("sat_256", 8'hFF, 16'hFFFF, 5, 24'h108001, 2496);
        run_frame("v16_b8001", 8'h10, 16'h8001, 5, 24'h4E0000, 258);
        run_frame("half_again", 8'h4E, 0, 0, 24'h4E0000, 1248);

        // Into the high phase of cycle 0, then reset asynchronously.
        for (int s = 1; s <= 10; s++) @(negedge clk);
        check_val("pre_rst_pwm_high", int'(pwm), 1);
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_pwm_low", int'(pwm), 0);
        check_val("async_rst_frame", int'(frame), 1);
        check_val("async_rst_ack", int'(ack), 0);
        @(posedge clk);
        release_reset();
        run_frame("post_rst_f1", 8'h00, 0, 0, 24'h4E0000, 0);
        run_frame("post_rst_f2", 8'h4E, 0, 0, 24'h4E0000, 1248);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_dac_gen.md
PWM_DAC_GEN -- requirements
Module: pwm_dac_gen

Interface
REQ-001 Parameter PERIOD, default 156: PWM cycle length in clocks; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: cycle counter width; SHALL satisfy 2^CNT_W >= PERIOD.
REQ-003 clk_i  input  1  clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 cfg_i  input  24  DAC config word from the AMS register file: [23:16] base duty V, [15:0] bit-spread pattern B.
REQ-006 pwm_o  output  1  PWM output, registered.
REQ-007 frame_o  output  1  one-clock strobe marking the first clock of a 16-cycle frame.
REQ-008 cfg_ack_o  output  1  one-clock strobe, high in the clock in which cfg_i is latched.

Function
REQ-009 cnt SHALL count 0..PERIOD-1 and wrap to 0; bcnt (4 bit) SHALL increment when cnt wraps, wrapping 15->0.
REQ-010 Frame: 16 PWM cycles, bcnt=0..15.
REQ-011 In the clock where cnt==PERIOD-1 and bcnt==15, v_r<=cfg_i[23:16], b_r<=cfg_i[15:0], and cfg_ack_o SHALL be high.
REQ-012 cfg_i SHALL be ignored in all other clocks; mid-frame changes take effect only at the next frame boundary.
REQ-013 thr register (9 bit) SHALL be updated in the clock where cnt==PERIOD-1 to V + B[k], where k = next bcnt and V, B are the values valid for the next cycle (newly latched values at a frame boundary).
REQ-014 The sum SHALL be 9-bit unsigned, with no overflow or wrap.
REQ-015 pwm_o(n+1) = (cnt(n) < thr).
REQ-016 Each PWM cycle k SHALL therefore have min(V+B[k], PERIOD) high clocks, contiguous from the cycle start, with 1-clock latency relative to cnt.
REQ-017 If V+B[k] >= PERIOD, pwm_o SHALL stay high for the whole cycle (saturation); no glitch low at cycle boundaries.
REQ-018 If V+B[k]==0, pwm_o SHALL stay low for the whole cycle.
REQ-019 frame_o SHALL be high exactly when cnt==0 and bcnt==0 (decoded from registers, no combinational path from inputs).
REQ-020 Average duty over a frame SHALL be (16*V + popcount(B)) / (16*PERIOD), unsaturated.

Reset
REQ-021 While rst_i is high: cnt=0, bcnt=0, v_r=0, b_r=0, thr=0, pwm_o=0, cfg_ack_o=0; frame_o=1, decoded from cnt=0/bcnt=0.
REQ-022 Assertion mid-cycle SHALL force pwm_o low immediately, without waiting for a clock edge.
REQ-023 After release, the first frame SHALL output pwm_o=0 for all cycles (thr=0).
REQ-024 The first cfg_i latch SHALL occur at clock 16*PERIOD-1 after release.

Verification
REQ-025 cfg_i=0x000000 held over 3 frames -> pwm_o constantly 0; cfg_ack_o pulses every 2496 clocks.
REQ-026 cfg_i=0x4E0000 -> from frame 2 onward every cycle shows 78 high then 78 low; frame_o period 2496 clocks.
REQ-027 cfg_i=0x0F0001 -> in each frame, cycle 0 has 16 high clocks and cycles 1..15 have 15 high clocks; total 241 per frame.
REQ-028 cfg_i=0x9B0001 -> cycle 0 constant high (156), cycles 1..15 155 high.
REQ-029 cfg_i=0xFF0000 -> pwm_o constant 1 across cycle boundaries (saturation).
REQ-030 cfg_i 0x4E0000->0x9C0000 at frame clock 1000 -> remainder of frame still 78 high per cycle; next frame constant high; exactly one cfg_ack_o per frame.
REQ-031 Assert rst_i asynchronously mid-high-phase -> pwm_o drops before the next clk_i edge.
REQ-032 After the REQ-031 reset, on release -> pwm_o stays 0 for 2496 clocks, then resumes per latched cfg_i.
